// File: rtl/sar_conv_scheduler.sv
// Round-robin scheduler that time-shares one SAR ADC among NCH channels:
// selects a channel, settles the mux, pulses cnvst, waits for eoc and returns the tagged result.
module sar_conv_scheduler #(
  parameter int NCH           = 4,
  parameter int CHW           = 2,
  parameter int DW            = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNVST_CYCLES  = 2,
  parameter int TIMEOUT       = 40
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] ch_sel,
  output logic           cnvst,
  input  logic           eoc,
  input  logic [DW-1:0]  sar,
  output logic [DW-1:0]  dout,
  output logic [CHW-1:0] dout_ch,
  output logic           dout_vld,
  output logic           timeout_err,
  output logic           busy
);

  localparam int CNTW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CHW-1:0]  last_q;
  logic            eoc_q;
  logic [CHW-1:0]  pick;
  logic            found;
  logic            completion;
  logic            wd_expire;

  // Round-robin search starts just after the channel served (or aborted) last.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latches are inferred.
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!found && req[(int'(last_q) + i) % NCH]) begin
        found = 1'b1;
        pick  = CHW'((int'(last_q) + i) % NCH);
      end
    end
  end

  // Only a fresh rising edge of eoc counts; a level already high on WAIT entry is stale.
  assign completion = (state_q == S_WAIT) && eoc && !eoc_q;
  assign wd_expire  = (state_q == S_WAIT) && (cnt_q == CNTW'(TIMEOUT - 1)) && !completion;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (found) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == CNTW'(SETTLE_CYCLES - 1)) state_d = S_START;
      S_START:  if (cnt_q == CNTW'(CNVST_CYCLES - 1)) state_d = S_WAIT;
      S_WAIT: begin
        if (completion)     state_d = S_DONE;
        else if (wd_expire) state_d = S_IDLE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNTW'(1);
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= CHW'(NCH - 1);
      eoc_q       <= 1'b0;
      ch_sel      <= '0;
      cnvst       <= 1'b0;
      dout        <= '0;
      dout_ch     <= '0;
      dout_vld    <= 1'b0;
      gnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      eoc_q       <= eoc;
      cnvst       <= (state_d == S_START);
      dout_vld    <= completion;
      gnt         <= completion ? (NCH'(1) << ch_sel) : '0;
      timeout_err <= wd_expire;
      if (state_q == S_IDLE && found) ch_sel <= pick;
      if (completion) begin
        dout    <= sar;
        dout_ch <= ch_sel;
      end
      if (state_q == S_DONE || wd_expire) last_q <= ch_sel;
    end
  end

endmodule

// File: tb/tb_sar_conv_scheduler.sv
// Self-checking bench for sar_conv_scheduler: a cycle-offset model checked every cycle,
// plus directed scenarios with hand-computed latencies, channel orders and data.
module tb_sar_conv_scheduler;

  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int DW  = 8;
  localparam int S   = 2;
  localparam int C   = 2;
  localparam int TO  = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] req;
  logic [NCH-1:0] gnt;
  logic [CHW-1:0] ch_sel;
  logic           cnvst;
  logic           eoc;
  logic [DW-1:0]  sar;
  logic [DW-1:0]  dout;
  logic [CHW-1:0] dout_ch;
  logic           dout_vld;
  logic           timeout_err;
  logic           busy;

  always #5 clk = ~clk;

  sar_conv_scheduler #(
    .NCH(NCH), .CHW(CHW), .DW(DW),
    .SETTLE_CYCLES(S), .CNVST_CYCLES(C), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .ch_sel(ch_sel),
    .cnvst(cnvst), .eoc(eoc), .sar(sar), .dout(dout), .dout_ch(dout_ch),
    .dout_vld(dout_vld), .timeout_err(timeout_err), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a conversion is a count of busy cycles since the grant, k = 1, 2, ...
  // k in 1..S settles, S+1..S+C drives cnvst, beyond that waits for an eoc edge or TO cycles.
  bit             m_busy, m_done, m_vld, m_terr, m_eoc_prev;
  int             m_k, m_ch, m_last, m_dout_ch;
  logic [DW-1:0]  m_dout;
  logic [NCH-1:0] m_gnt;

  function automatic int rr_pick(input logic [NCH-1:0] r, input int last);
    for (int i = 1; i <= NCH; i++) begin
      if (r[(last + i) % NCH]) return (last + i) % NCH;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_done <= 0; m_vld <= 0; m_terr <= 0; m_eoc_prev <= 0;
      m_k <= 0; m_ch <= 0; m_last <= NCH - 1; m_dout_ch <= 0;
      m_dout <= '0; m_gnt <= '0;
    end else begin
      m_eoc_prev <= eoc;
      m_vld      <= 0;
      m_terr     <= 0;
      m_gnt      <= '0;
      if (!m_busy) begin
        if (req != 0) begin
          m_busy <= 1;
          m_k    <= 1;
          m_ch   <= rr_pick(req, m_last);
        end
      end else if (m_done) begin
        m_busy <= 0;
        m_done <= 0;
        m_last <= m_ch;
      end else if (m_k > S + C && eoc && !m_eoc_prev) begin
        m_dout    <= sar;
        m_dout_ch <= m_ch;
        m_vld     <= 1;
        m_gnt     <= 4'b0001 << m_ch;
        m_done    <= 1;
      end else if (m_k - (S + C) == TO) begin
        m_terr <= 1;
        m_busy <= 0;
        m_last <= m_ch;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",        busy,        m_busy);
      check("cnvst",       cnvst,       m_busy && !m_done && m_k >= S + 1 && m_k <= S + C);
      check("ch_sel",      ch_sel,      m_ch);
      check("dout",        dout,        m_dout);
      check("dout_ch",     dout_ch,     m_dout_ch);
      check("dout_vld",    dout_vld,    m_vld);
      check("gnt",         gnt,         m_gnt);
      check("timeout_err", timeout_err, m_terr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cnvst(input logic v);
    int n = 0;
    while (cnvst !== v && n < 100) begin tick(); n++; end
    check("cnvst_level_reached", cnvst, v);
  endtask

  // One full conversion: eoc rises dly cycles after cnvst falls; req switches when the result shows.
  task automatic serve(input int dly, input logic [NCH-1:0] req_after,
                       output int ch, output logic [DW-1:0] d);
    int n;
    wait_cnvst(1'b1);
    n = 0;
    while (cnvst === 1'b1 && n < 20) begin tick(); n++; end
    check("cnvst_width", n, C);
    repeat (dly) tick();
    eoc = 1'b1;
    n = 0;
    while (dout_vld !== 1'b1 && n < 5) begin tick(); n++; end
    check("eoc_to_vld", n, 1);
    ch  = int'(dout_ch);
    d   = dout;
    req = req_after;
    eoc = 1'b0;
  endtask

  initial begin
    int             ch, n, vld_cnt;
    logic [DW-1:0]  d;
    int             seq_a[5];
    int             seq_b[4];
    int             exp_a[5];
    int             exp_b[4];
    exp_a = '{0, 1, 2, 3, 0};
    exp_b = '{1, 3, 1, 3};

    rst = 1'b0; req = 4'b1111; eoc = 1'b0; sar = '0;
    #1 chk_en = 1'b1;

    // Reset held with requests and a toggling eoc: nothing may start.
    for (int i = 0; i < 6; i++) begin
      tick();
      eoc = ~eoc;
      check("rst_cnvst", cnvst, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    eoc = 1'b0;
    tick();
    rst = 1'b1;

    // Round robin with everything requesting, then only ch1/ch3.
    for (int i = 0; i < 5; i++) begin
      sar = DW'(8'h10 + i);
      serve(10, (i == 4) ? 4'b1010 : 4'b1111, ch, d);
      seq_a[i] = ch;
      check("rr_all_data", d, 8'h10 + i);
    end
    for (int i = 0; i < 4; i++) begin
      serve(10, (i == 3) ? 4'b0000 : 4'b1010, ch, d);
      seq_b[i] = ch;
    end
    for (int i = 0; i < 5; i++) check("rr_all_order", seq_a[i], exp_a[i]);
    for (int i = 0; i < 4; i++) check("rr_1010_order", seq_b[i], exp_b[i]);
    tick();

    // Single request on ch2; req is dropped during SETTLE and must not abort.
    req = 4'b0100;
    sar = 8'hA5;
    tick();
    req = 4'b0000;
    n = 1;
    while (cnvst !== 1'b1 && n < 20) begin tick(); n++; end
    check("req_to_cnvst", n, 3);
    check("single_ch_sel", ch_sel, 2);
    serve(12, 4'b0000, ch, d);
    check("single_dout", d, 8'hA5);
    check("single_dout_ch", ch, 2);
    check("single_gnt", gnt, 4'b0100);
    tick();
    check("single_vld_drop", dout_vld, 1'b0);
    check("single_gnt_drop", gnt, 4'b0000);
    check("single_dout_hold", dout, 8'hA5);

    // Watchdog: eoc never rises on ch0.
    req = 4'b0001;
    sar = 8'h3C;
    wait_cnvst(1'b1);
    req = 4'b0000;
    wait_cnvst(1'b0);
    n = 0; vld_cnt = 0;
    while (timeout_err !== 1'b1 && n < 60) begin
      tick(); n++;
      if (dout_vld === 1'b1) vld_cnt++;
    end
    check("timeout_latency", n, TO);
    check("timeout_no_vld", vld_cnt, 0);
    check("timeout_dout_hold", dout, 8'hA5);
    check("timeout_idle", busy, 1'b0);
    req = 4'b0011;
    sar = 8'h5A;
    serve(5, 4'b0000, ch, d);
    check("after_timeout_ch", ch, 1);
    check("after_timeout_dout", d, 8'h5A);
    tick();

    // Stale eoc: held high across WAIT entry, then a genuine fall and rise.
    req = 4'b1000;
    eoc = 1'b1;
    sar = 8'hC3;
    wait_cnvst(1'b1);
    req = 4'b0000;
    wait_cnvst(1'b0);
    vld_cnt = 0;
    repeat (8) begin tick(); if (dout_vld === 1'b1) vld_cnt++; end
    check("stale_eoc_ignored", vld_cnt, 0);
    eoc = 1'b0;
    repeat (2) tick();
    eoc = 1'b1;
    repeat (4) begin tick(); if (dout_vld === 1'b1) vld_cnt++; end
    check("fresh_eoc_single", vld_cnt, 1);
    check("fresh_eoc_dout", dout, 8'hC3);
    check("fresh_eoc_ch", dout_ch, 3);
    eoc = 1'b0;
    repeat (3) tick();

    // Reset during WAIT: outputs drop at once and nothing is reported.
    req = 4'b0001;
    wait_cnvst(1'b1);
    req = 4'b0000;
    wait_cnvst(1'b0);
    repeat (3) tick();
    #1 rst = 1'b0;
    #1;
    check("midrst_cnvst", cnvst, 1'b0);
    check("midrst_busy", busy, 1'b0);
    eoc = 1'b1;
    repeat (3) begin
      tick();
      check("midrst_no_vld", dout_vld, 1'b0);
      check("midrst_no_err", timeout_err, 1'b0);
    end
    eoc = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", busy, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sar_conv_scheduler.md
Name: sar_conv_scheduler

Overview:
- Time-shares the single SAR ADC (`sar_logic`) between NCH analog input channels.
- Arbitrates channel requests round-robin and drives the analog mux select.
- Issues the `cnvst` start pulse, waits for `eoc`, captures the SAR code and returns it tagged with its channel.
- Sits between the channel requesters and `sar_logic`; has a watchdog for conversions that never complete.

Parameters:
- NCH, 4: number of requesting channels (2..16).
- CHW, 2: channel index width, equal to clog2(NCH).
- DW, 8: SAR result width.
- SETTLE_CYCLES, 2: mux settle cycles before start (1..15).
- CNVST_CYCLES, 2: `cnvst` high width in cycles (1..15).
- TIMEOUT, 40: maximum WAIT cycles before abort (2..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NCH  per-channel conversion request (level).
- gnt  out  NCH  one-hot; 1-cycle pulse when that channel's result is delivered.
- ch_sel  out  CHW  analog mux select; held constant from SETTLE through WAIT.
- cnvst  out  1  conversion start to `sar_logic`.
- eoc  in  1  end-of-conversion from `sar_logic`.
- sar  in  DW  conversion result from `sar_logic`.
- dout  out  DW  captured result; holds until the next capture.
- dout_ch  out  CHW  channel of `dout`.
- dout_vld  out  1  1-cycle pulse with `dout`/`dout_ch`.
- timeout_err  out  1  1-cycle pulse on watchdog abort.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0: `gnt`, `ch_sel`, `cnvst`, `dout`, `dout_ch`, `dout_vld`, `timeout_err`, `busy`.
  - Round-robin pointer last=NCH-1, so ch0 has first priority.
  - Counters 0; `eoc_q` 0.
  - Reset mid-operation aborts immediately; `cnvst` drops in the same instant. No result or error is reported.
- States: IDLE, SETTLE, START, WAIT, DONE. A single counter `cnt` is cleared on every state entry.
- IDLE:
  - If `req` is nonzero, select the first set bit searching last+1, last+2, ... modulo NCH.
  - Register it into `ch_sel` and go to SETTLE.
  - `req` is sampled only in IDLE. Deasserting it later does not abort.
- SETTLE:
  - `busy`=1. Stay SETTLE_CYCLES cycles, then go to START.
- START:
  - `cnvst`=1 (registered output) for exactly CNVST_CYCLES cycles, then go to WAIT with `cnvst`=0.
- WAIT:
  - `eoc_q` registers `eoc` every cycle.
  - Completion is a rising edge only: `eoc`=1 and `eoc_q`=0 while in WAIT. An `eoc` already high on WAIT entry is stale and ignored until it falls and rises again.
  - On completion: capture `sar` into `dout` and `ch_sel` into `dout_ch` on that clock edge, then go to DONE.
  - If `cnt` reaches TIMEOUT-1 with no completion: pulse `timeout_err` for the next cycle, set last=`ch_sel`, go to IDLE. `dout` is unchanged and there is no `dout_vld`/`gnt`.
  - Completion and timeout in the same cycle: completion wins.
- DONE (1 cycle):
  - `dout_vld`=1 and `gnt[dout_ch]`=1; last=`ch_sel`; go to IDLE.
- Latency:
  - From the IDLE cycle that sees `req` to the first `cnvst`=1 cycle: 1+SETTLE_CYCLES cycles.
  - From the `eoc` rising edge sampled to `dout_vld`: 1 cycle.
  - Minimum gap between `dout_vld` and the next SETTLE entry: 1 cycle (the IDLE arbitration cycle).
- Round-robin guarantee: with all requests asserted, every channel is served once per NCH conversions.
- `ch_sel` holds its last value in IDLE/DONE. `busy` is combinational from state.

Test Plan:
1. Reset: hold rst=0 with `req`=4'b1111 and `eoc` toggling → all outputs 0 and no `cnvst`. Release rst → first conversion on ch0 (`ch_sel`=0).
2. Single request: `req`=4'b0100; `eoc` rises 12 cycles after `cnvst` falls; `sar`=8'hA5.
   - `ch_sel`=2; `cnvst` starts 3 cycles after `req` is seen and is high exactly 2 cycles.
   - The cycle after the `eoc` rise: `dout`=8'hA5, `dout_ch`=2, `dout_vld`=1, `gnt`=4'b0100, each high exactly one cycle.
3. Round-robin: `req`=4'b1111 held; `eoc` model responds after 10 cycles → `dout_ch` sequence 0,1,2,3,0. With `req`=4'b1010 → 1,3,1,3.
4. Timeout: `req`=4'b0001, `eoc` never rises.
   - `timeout_err` pulses once 40 WAIT cycles after `cnvst` falls.
   - No `dout_vld`; `dout` keeps its previous value; IDLE follows.
   - With `req`=4'b0011, ch1 is served next.
5. Stale `eoc`: `eoc` held 1 from before WAIT entry → no completion. `eoc` 0 then 1 later → single capture.
6. Mid-operation events:
   - Assert rst during WAIT → `cnvst`/`busy` 0 immediately, no `dout_vld` or `timeout_err`.
   - Drop `req` during SETTLE → the conversion still completes and delivers `dout_vld`.
